// File: rtl/lock_keypad_ctrl.sv
// Keypad lock controller: collects a 4-digit BCD code, requests an external
// comparison, then opens for UNLOCK_CYCLES or counts failures up to an alarm lockout.
module lock_keypad_ctrl #(
  parameter int unsigned UNLOCK_CYCLES  = 50,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        equal,
  output logic [15:0] pressed_code,
  output logic        check,
  output logic [2:0]  digit_count,
  output logic        unlocked,
  output logic        alarm
);

  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [UW-1:0] UNL_LAST = UW'(UNLOCK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, WAIT_EQ, OPEN, ALARM} state_t;

  state_t        state, state_n;
  logic [15:0]   code_n;
  logic [2:0]    count_n;
  logic [FW-1:0] fails, fails_n;
  logic [TW-1:0] timer, timer_n;
  logic [UW-1:0] ucnt, ucnt_n;
  logic          is_digit;

  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_n = state;
    code_n  = pressed_code;
    count_n = digit_count;
    fails_n = fails;
    timer_n = timer;
    ucnt_n  = ucnt;
    case (state)
      IDLE: begin
        if (key_valid && is_digit) begin
          code_n  = {12'h000, key_code};
          count_n = 3'd1;
          timer_n = '0;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (key_valid) begin
          // any strobe, even an ignored one, restarts the idle timeout
          timer_n = '0;
          if (is_digit) begin
            if (digit_count < 3'd4) begin
              code_n  = {pressed_code[11:0], key_code};
              count_n = digit_count + 3'd1;
            end
          end else if (key_code == 4'hC) begin
            code_n  = '0;
            count_n = '0;
            state_n = IDLE;
          end else if (key_code == 4'hE && digit_count == 3'd4) begin
            state_n = CHECK;
          end
        end else if (timer == TMO_LAST) begin
          code_n  = '0;
          count_n = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      CHECK: state_n = WAIT_EQ;
      WAIT_EQ: begin
        code_n  = '0;
        count_n = '0;
        if (equal) begin
          fails_n = '0;
          ucnt_n  = '0;
          state_n = OPEN;
        end else begin
          if (fails < FAIL_MAX) fails_n = fails + 1'b1;
          state_n = (fails_n == FAIL_MAX) ? ALARM : IDLE;
        end
      end
      OPEN: begin
        if (ucnt == UNL_LAST) begin
          ucnt_n  = '0;
          state_n = IDLE;
        end else begin
          ucnt_n = ucnt + 1'b1;
        end
      end
      ALARM:   state_n = ALARM;
      default: state_n = IDLE;
    endcase
  end

  // outputs are flopped from the next state so they are clean decodes
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      pressed_code <= '0;
      digit_count  <= '0;
      fails        <= '0;
      timer        <= '0;
      ucnt         <= '0;
      check        <= 1'b0;
      unlocked     <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      pressed_code <= code_n;
      digit_count  <= count_n;
      fails        <= fails_n;
      timer        <= timer_n;
      ucnt         <= ucnt_n;
      check        <= (state_n == CHECK);
      unlocked     <= (state_n == OPEN);
      alarm        <= (state_n == ALARM);
    end
  end

endmodule

// File: tb/tb_lock_keypad_ctrl.sv
// Self-checking bench for lock_keypad_ctrl: a scoreboard holds the expected
// code at each check pulse and the expected length of each unlock window.
module tb_lock_keypad_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        equal;
  logic [15:0] pressed_code;
  logic        check;
  logic [2:0]  digit_count;
  logic        unlocked;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_code[$];
  int          q_unl[$];
  logic        eq_resp = 1'b0;
  logic        mon_en  = 1'b0;

  lock_keypad_ctrl #(.UNLOCK_CYCLES(50), .MAX_TRIES(3), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code), .equal(equal),
    .pressed_code(pressed_code), .check(check), .digit_count(digit_count),
    .unlocked(unlocked), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // comparator model: answers eq_resp in the cycle after the check pulse
  initial begin
    logic prev_check;
    prev_check = 1'b0;
    equal = 1'b0;
    forever begin
      @(negedge clk);
      equal = prev_check ? eq_resp : 1'b0;
      prev_check = (check === 1'b1);
    end
  end

  // output monitor: pops the scoreboard on check pulses and unlock windows
  initial begin
    logic        mprev_check;
    logic        mprev_unl;
    int          run;
    logic [15:0] exp_code;
    int          exp_len;
    mprev_check = 1'b0;
    mprev_unl = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if ((check & unlocked) | (check & alarm) | (unlocked & alarm)) begin
          errors++;
          $display("FAIL excl: check=%b unlocked=%b alarm=%b, required at most one high", check, unlocked, alarm);
        end
        if (check === 1'b1) begin
          checks++;
          if (mprev_check) begin
            errors++;
            $display("FAIL check_width: check high 2+ cycles, required 1");
          end else if (q_code.size() == 0) begin
            errors++;
            $display("FAIL check_unexpected: pressed_code=%h, required no check pulse", pressed_code);
          end else begin
            exp_code = q_code.pop_front();
            if (pressed_code !== exp_code) begin
              errors++;
              $display("FAIL check_code: got %h, required %h", pressed_code, exp_code);
            end
          end
        end
        if (unlocked === 1'b1) run++;
        if (mprev_unl && unlocked !== 1'b1) begin
          checks++;
          if (q_unl.size() == 0) begin
            errors++;
            $display("FAIL unlock_unexpected: window of %0d cycles, required none", run);
          end else begin
            exp_len = q_unl.pop_front();
            if (run != exp_len) begin
              errors++;
              $display("FAIL unlock_len: got %0d, required %0d", run, exp_len);
            end
          end
          run = 0;
        end
        mprev_check = (check === 1'b1);
        mprev_unl = (unlocked === 1'b1);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  task automatic idle_state(input string name);
    checks++;
    if (pressed_code !== 16'h0000 || digit_count !== 3'd0 || check !== 1'b0 ||
        unlocked !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL %s: code=%h cnt=%0d chk=%b unl=%b alm=%b, required 0000/0/0/0/0",
               name, pressed_code, digit_count, check, unlocked, alarm);
    end
  endtask

  // four digits then enter; scoreboard gets the code and, on success, the window length
  task automatic enter_code(input logic [15:0] code, input logic resp);
    eq_resp = resp;
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
    checks++;
    if (pressed_code !== code || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL entry: code=%h cnt=%0d, required %h/4", pressed_code, digit_count, code);
    end
    q_code.push_back(code);
    if (resp) q_unl.push_back(50);
    press(4'hE);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    idle_state("reset");
    clr = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_open();
    enter_code(16'h1234, 1'b1);
    checks++;
    if (unlocked !== 1'b1 || pressed_code !== 16'h0000) begin
      errors++;
      $display("FAIL open_state: unl=%b code=%h, required 1/0000", unlocked, pressed_code);
    end
    repeat (60) @(negedge clk);
    idle_state("open_done");
  endtask

  task automatic test_clear_overflow();
    press(4'h1);
    press(4'h2);
    checks++;
    if (digit_count !== 3'd2 || pressed_code !== 16'h0012) begin
      errors++;
      $display("FAIL partial: code=%h cnt=%0d, required 0012/2", pressed_code, digit_count);
    end
    press(4'hC);
    idle_state("clear_key");
    press(4'hA);
    idle_state("ignored_idle");
    eq_resp = 1'b1;
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    checks++;
    if (pressed_code !== 16'h9876 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL fifth_digit: code=%h cnt=%0d, required 9876/4", pressed_code, digit_count);
    end
    q_code.push_back(16'h9876);
    q_unl.push_back(50);
    press(4'hE);
    repeat (60) @(negedge clk);
    idle_state("overflow_done");
  endtask

  task automatic test_alarm();
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h5555, 1'b0);
      checks++;
      if (alarm !== (i == 2) || unlocked !== 1'b0) begin
        errors++;
        $display("FAIL alarm_try%0d: alarm=%b unl=%b, required %b/0", i, alarm, unlocked, (i == 2));
      end
    end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
    repeat (4) @(negedge clk);
    checks++;
    if (alarm !== 1'b1 || digit_count !== 3'd0 || pressed_code !== 16'h0000) begin
      errors++;
      $display("FAIL alarm_hold: alarm=%b cnt=%0d code=%h, required 1/0/0000", alarm, digit_count, pressed_code);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle_state("alarm_clr");
  endtask

  task automatic test_timeout();
    press(4'h1);
    press(4'h2);
    repeat (998) @(negedge clk);
    checks++;
    if (digit_count !== 3'd2 || pressed_code !== 16'h0012) begin
      errors++;
      $display("FAIL pre_timeout: code=%h cnt=%0d, required 0012/2", pressed_code, digit_count);
    end
    repeat (2) @(negedge clk);
    idle_state("timeout");
    press(4'h1); press(4'h2); press(4'h3); press(4'hE);
    repeat (4) @(negedge clk);
    checks++;
    if (digit_count !== 3'd3 || pressed_code !== 16'h0123) begin
      errors++;
      $display("FAIL short_enter: code=%h cnt=%0d, required 0123/3", pressed_code, digit_count);
    end
    press(4'hC);
    idle_state("short_clear");
  endtask

  task automatic test_fail_reset();
    enter_code(16'h1111, 1'b0);
    enter_code(16'h2222, 1'b0);
    enter_code(16'h4321, 1'b1);
    repeat (60) @(negedge clk);
    enter_code(16'h3333, 1'b0);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL fail_reset: alarm=%b, required 0", alarm);
    end
    enter_code(16'h3333, 1'b0);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL fail_second: alarm=%b, required 0", alarm);
    end
  endtask

  task automatic test_clr_open();
    int waited;
    eq_resp = 1'b1;
    press(4'h7); press(4'h7); press(4'h0); press(4'h1);
    q_code.push_back(16'h7701);
    q_unl.push_back(10);
    press(4'hE);
    waited = 0;
    while (unlocked !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL clr_open_wait: unlocked=%b, required 1 within 10 cycles", unlocked);
    end
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    idle_state("clr_open");
    clr = 1'b0;
    repeat (3) @(negedge clk);
    idle_state("clr_open_after");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    clr = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    test_reset();
    test_open();
    test_clear_overflow();
    test_alarm();
    test_timeout();
    test_fail_reset();
    test_clr_open();
    repeat (2) @(negedge clk);
    checks++;
    if (q_code.size() != 0 || q_unl.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d codes, %0d windows outstanding, required 0/0", q_code.size(), q_unl.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
